// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared state encoding and default sizing for the SPI transaction arbiter
package spi_arb_pkg;

    localparam int SPI_ARB_DEFAULT_REQUESTERS = 2;
    localparam int SPI_ARB_DEFAULT_WIDTH      = 16;
    localparam int SPI_ARB_DEFAULT_TIMEOUT    = 4096;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DELIVER   = 2'd3
    } spi_arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin winner search starting after last_grant
module rr_priority_picker
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQUESTERS = SPI_ARB_DEFAULT_REQUESTERS
) (
    input  logic [NUM_REQUESTERS-1:0]         req_valid,
    input  logic [$clog2(NUM_REQUESTERS)-1:0] last_grant,
    output logic [$clog2(NUM_REQUESTERS)-1:0] winner,
    output logic                              any_valid
);

    localparam int GW = $clog2(NUM_REQUESTERS);

    logic [GW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest valid requester is written last.
    always_comb begin
        winner    = '0;
        cand      = '0;
        any_valid = |req_valid;
        for (int k = NUM_REQUESTERS; k >= 1; k--) begin
            cand = GW'((int'(last_grant) + k) % NUM_REQUESTERS);
            if (req_valid[cand]) begin
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/spi_transaction_arbiter.sv
// rtl/spi_transaction_arbiter.sv - shares one spi_master among requesters, one transaction in flight
module spi_transaction_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQUESTERS = SPI_ARB_DEFAULT_REQUESTERS,
    parameter int TRANSFER_WIDTH = SPI_ARB_DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = SPI_ARB_DEFAULT_TIMEOUT
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_REQUESTERS*TRANSFER_WIDTH-1:0] req_tdata,
    input  logic [NUM_REQUESTERS-1:0]                req_tvalid,
    output logic [NUM_REQUESTERS-1:0]                req_tready,
    output logic [TRANSFER_WIDTH-1:0]                rsp_tdata,
    output logic [NUM_REQUESTERS-1:0]                rsp_tvalid,
    input  logic [NUM_REQUESTERS-1:0]                rsp_tready,
    output logic [TRANSFER_WIDTH-1:0]                cmd_tdata,
    output logic                                     cmd_tvalid,
    input  logic                                     cmd_tready,
    input  logic [TRANSFER_WIDTH-1:0]                miso_tdata,
    input  logic                                     miso_tvalid,
    output logic                                     miso_tready,
    output logic [$clog2(NUM_REQUESTERS)-1:0]        grant,
    output logic                                     busy,
    output logic                                     timeout,
    output logic [7:0]                               dropped_count
);

    localparam int GW = $clog2(NUM_REQUESTERS);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [GW-1:0] LAST_GRANT_RST = GW'(NUM_REQUESTERS - 1);
    localparam logic [CW-1:0] CNT_LAST       = CW'(TIMEOUT_CYCLES - 1);

    spi_arb_state_t            state_q, state_d;
    logic [GW-1:0]             grant_q, grant_d;
    logic [GW-1:0]             last_grant_q, last_grant_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [TRANSFER_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [NUM_REQUESTERS-1:0] rsp_valid_q, rsp_valid_d;
    logic                      busy_q, busy_d;
    logic                      timeout_q, timeout_d;
    logic                      miso_ready_q, miso_ready_d;
    logic [7:0]                dropped_q, dropped_d;

    logic [GW-1:0]             rr_winner;
    logic                      rr_any;
    logic [TRANSFER_WIDTH-1:0] req_words [NUM_REQUESTERS];

    for (genvar i = 0; i < NUM_REQUESTERS; i++) begin : g_unpack
        assign req_words[i] = req_tdata[i*TRANSFER_WIDTH +: TRANSFER_WIDTH];
    end

    rr_priority_picker #(
        .NUM_REQUESTERS(NUM_REQUESTERS)
    ) u_picker (
        .req_valid (req_tvalid),
        .last_grant(last_grant_q),
        .winner    (rr_winner),
        .any_valid (rr_any)
    );

    // The command path is the only unregistered route through the block.
    assign cmd_tdata = req_words[grant_q];

    always_comb begin
        cmd_tvalid = 1'b0;
        req_tready = '0;
        if (state_q == ISSUE) begin
            cmd_tvalid          = req_tvalid[grant_q];
            req_tready[grant_q] = cmd_tready;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        timeout_d    = 1'b0;
        dropped_d    = dropped_q;

        case (state_q)
            IDLE: begin
                // Late responses from an expired transaction are swallowed here.
                if (miso_tvalid && miso_ready_q && (dropped_q != 8'hFF)) begin
                    dropped_d = dropped_q + 8'd1;
                end
                if (rr_any) begin
                    grant_d = rr_winner;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (req_tvalid[grant_q] && cmd_tready) begin
                    cnt_d   = '0;
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (miso_tvalid && miso_ready_q) begin
                    rsp_data_d           = miso_tdata;
                    rsp_valid_d          = '0;
                    rsp_valid_d[grant_q] = 1'b1;
                    state_d              = DELIVER;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d    = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DELIVER: begin
                if (rsp_tready[grant_q]) begin
                    rsp_valid_d  = '0;
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        miso_ready_d = (state_d == IDLE) || (state_d == WAIT_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_GRANT_RST;
            cnt_q        <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
            busy_q       <= 1'b0;
            timeout_q    <= 1'b0;
            miso_ready_q <= 1'b1;
            dropped_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            timeout_q    <= timeout_d;
            miso_ready_q <= miso_ready_d;
            dropped_q    <= dropped_d;
        end
    end

    assign grant         = grant_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;
    assign rsp_tdata     = rsp_data_q;
    assign rsp_tvalid    = rsp_valid_q;
    assign miso_tready   = miso_ready_q;
    assign dropped_count = dropped_q;

endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// tb/tb_spi_transaction_arbiter.sv - directed self-checking bench for spi_transaction_arbiter
module tb_spi_transaction_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance a: long timeout; instance b: TIMEOUT_CYCLES = 16
    logic [31:0] a_req_tdata, b_req_tdata;
    logic [1:0]  a_req_tvalid, b_req_tvalid, a_req_tready, b_req_tready;
    logic [15:0] a_rsp_tdata, b_rsp_tdata;
    logic [1:0]  a_rsp_tvalid, b_rsp_tvalid, a_rsp_tready, b_rsp_tready;
    logic [15:0] a_cmd_tdata, b_cmd_tdata;
    logic        a_cmd_tvalid, b_cmd_tvalid, a_cmd_tready, b_cmd_tready;
    logic [15:0] a_miso_tdata, b_miso_tdata;
    logic        a_miso_tvalid, b_miso_tvalid, a_miso_tready, b_miso_tready;
    logic [0:0]  a_grant, b_grant;
    logic        a_busy, b_busy, a_timeout, b_timeout;
    logic [7:0]  a_dropped, b_dropped;

    int checks = 0;
    int failures = 0;

    spi_transaction_arbiter #(
        .NUM_REQUESTERS(2), .TRANSFER_WIDTH(16), .TIMEOUT_CYCLES(256)
    ) dut_a (
        .clk(clk), .reset(reset),
        .req_tdata(a_req_tdata), .req_tvalid(a_req_tvalid), .req_tready(a_req_tready),
        .rsp_tdata(a_rsp_tdata), .rsp_tvalid(a_rsp_tvalid), .rsp_tready(a_rsp_tready),
        .cmd_tdata(a_cmd_tdata), .cmd_tvalid(a_cmd_tvalid), .cmd_tready(a_cmd_tready),
        .miso_tdata(a_miso_tdata), .miso_tvalid(a_miso_tvalid), .miso_tready(a_miso_tready),
        .grant(a_grant), .busy(a_busy), .timeout(a_timeout), .dropped_count(a_dropped)
    );

    spi_transaction_arbiter #(
        .NUM_REQUESTERS(2), .TRANSFER_WIDTH(16), .TIMEOUT_CYCLES(16)
    ) dut_b (
        .clk(clk), .reset(reset),
        .req_tdata(b_req_tdata), .req_tvalid(b_req_tvalid), .req_tready(b_req_tready),
        .rsp_tdata(b_rsp_tdata), .rsp_tvalid(b_rsp_tvalid), .rsp_tready(b_rsp_tready),
        .cmd_tdata(b_cmd_tdata), .cmd_tvalid(b_cmd_tvalid), .cmd_tready(b_cmd_tready),
        .miso_tdata(b_miso_tdata), .miso_tvalid(b_miso_tvalid), .miso_tready(b_miso_tready),
        .grant(b_grant), .busy(b_busy), .timeout(b_timeout), .dropped_count(b_dropped)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0]  oh;
    logic [15:0] w0, w1;
    logic        ok_a, ok_b, ok_c, ok_d;

    initial begin
        a_req_tdata = '0; a_req_tvalid = '0; a_rsp_tready = '0; a_cmd_tready = 1'b0;
        a_miso_tdata = '0; a_miso_tvalid = 1'b0;
        b_req_tdata = '0; b_req_tvalid = '0; b_rsp_tready = '0; b_cmd_tready = 1'b0;
        b_miso_tdata = '0; b_miso_tvalid = 1'b0;

        // Reset state
        step(); step();
        reset = 1'b0;
        chk("rst_busy", a_busy, 0);
        chk("rst_grant", a_grant, 0);
        chk("rst_rsp_tvalid", a_rsp_tvalid, 0);
        chk("rst_req_tready", a_req_tready, 0);
        chk("rst_cmd_tvalid", a_cmd_tvalid, 0);
        chk("rst_timeout", a_timeout, 0);
        chk("rst_dropped", a_dropped, 0);
        chk("rst_miso_tready", a_miso_tready, 1);

        // Single requester 0, slow response
        a_req_tdata = {16'h0000, 16'hB200};
        a_req_tvalid = 2'b01;
        step();
        chk("s_busy", a_busy, 1);
        chk("s_grant", a_grant, 0);
        chk("s_cmd_tvalid", a_cmd_tvalid, 1);
        chk("s_cmd_tdata", a_cmd_tdata, 16'hB200);
        chk("s_req_tready_stall", a_req_tready, 2'b00);
        a_cmd_tready = 1'b1;
        #1;
        chk("s_req_tready", a_req_tready, 2'b01);
        step();
        a_req_tvalid = 2'b00;
        a_cmd_tready = 1'b0;
        chk("s_wait_miso_tready", a_miso_tready, 1);
        chk("s_wait_cmd_tvalid", a_cmd_tvalid, 0);
        repeat (199) step();
        a_miso_tdata = 16'h00E5;
        a_miso_tvalid = 1'b1;
        step();
        a_miso_tvalid = 1'b0;
        chk("s_rsp_tvalid", a_rsp_tvalid, 2'b01);
        chk("s_rsp_tdata", a_rsp_tdata, 16'h00E5);
        chk("s_deliver_miso_tready", a_miso_tready, 0);
        a_rsp_tready = 2'b01;
        step();
        a_rsp_tready = 2'b00;
        chk("s_busy_done", a_busy, 0);
        chk("s_rsp_tvalid_done", a_rsp_tvalid, 0);
        chk("s_no_timeout_dropped", a_dropped, 0);

        // Round-robin with both requesters continuously valid
        reset = 1'b1; step(); reset = 1'b0;
        a_req_tvalid = 2'b11;
        a_cmd_tready = 1'b1;
        #1;
        chk("rr_idle_req_tready", a_req_tready, 2'b00);
        for (int t = 0; t < 6; t++) begin
            w0 = 16'hA000 + 16'(t);
            w1 = 16'hC100 + 16'(t);
            a_req_tdata = {w1, w0};
            oh = 2'b01 << (t % 2);
            step();
            chk($sformatf("rr_grant_%0d", t), a_grant, t % 2);
            chk($sformatf("rr_cmd_tdata_%0d", t), a_cmd_tdata, (t % 2) ? w1 : w0);
            chk($sformatf("rr_req_tready_%0d", t), a_req_tready, oh);
            step();
            a_miso_tdata = 16'h5000 + 16'(t);
            a_miso_tvalid = 1'b1;
            step();
            a_miso_tvalid = 1'b0;
            chk($sformatf("rr_rsp_tvalid_%0d", t), a_rsp_tvalid, oh);
            chk($sformatf("rr_rsp_tdata_%0d", t), a_rsp_tdata, 16'h5000 + 16'(t));
            a_rsp_tready = 2'b11;
            step();
            a_rsp_tready = 2'b00;
        end

        // Requester 1 stalls the response for 50 cycles while requester 0 waits
        a_req_tvalid = 2'b10;
        a_req_tdata = {16'h7777, 16'h1111};
        step();
        chk("hold_grant", a_grant, 1);
        step();
        a_req_tvalid = 2'b01;
        a_miso_tdata = 16'hABCD;
        a_miso_tvalid = 1'b1;
        step();
        a_miso_tvalid = 1'b0;
        ok_a = 1'b1; ok_b = 1'b1; ok_c = 1'b1; ok_d = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (a_rsp_tvalid !== 2'b10) ok_a = 1'b0;
            if (a_rsp_tdata !== 16'hABCD) ok_b = 1'b0;
            if (a_miso_tready !== 1'b0) ok_c = 1'b0;
            if (a_grant !== 1'b1 || a_cmd_tvalid !== 1'b0 || a_busy !== 1'b1) ok_d = 1'b0;
        end
        chk("hold_rsp_tvalid_stable", ok_a, 1);
        chk("hold_rsp_tdata_stable", ok_b, 1);
        chk("hold_miso_tready_low", ok_c, 1);
        chk("hold_no_new_grant", ok_d, 1);
        a_rsp_tready = 2'b10;
        step();
        a_rsp_tready = 2'b00;
        chk("hold_release_rsp_tvalid", a_rsp_tvalid, 0);
        step();
        chk("hold_next_grant", a_grant, 0);

        // Reset while waiting for a response
        reset = 1'b1; step(); reset = 1'b0;
        a_req_tvalid = 2'b01;
        a_req_tdata = {16'h0000, 16'h1357};
        step(); step();
        a_req_tvalid = 2'b00;
        step(); step();
        chk("mid_busy_before", a_busy, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_busy", a_busy, 0);
        chk("mid_rsp_tvalid", a_rsp_tvalid, 0);
        a_miso_tdata = 16'hDEAD;
        a_miso_tvalid = 1'b1;
        step();
        a_miso_tvalid = 1'b0;
        chk("mid_dropped", a_dropped, 1);
        chk("mid_no_rsp", a_rsp_tvalid, 0);
        a_req_tvalid = 2'b10;
        a_req_tdata = {16'h2468, 16'h0000};
        step();
        chk("mid_grant1", a_grant, 1);
        chk("mid_cmd_tdata", a_cmd_tdata, 16'h2468);
        step();
        a_req_tvalid = 2'b00;
        a_miso_tdata = 16'h2222;
        a_miso_tvalid = 1'b1;
        step();
        a_miso_tvalid = 1'b0;
        chk("mid_rsp_tvalid1", a_rsp_tvalid, 2'b10);
        chk("mid_rsp_tdata1", a_rsp_tdata, 16'h2222);
        a_rsp_tready = 2'b10;
        step();
        a_rsp_tready = 2'b00;
        chk("mid_busy_done", a_busy, 0);

        // Timeout after 16 cycles on instance b
        b_req_tvalid = 2'b01;
        b_req_tdata = {16'h0000, 16'h0F0F};
        b_cmd_tready = 1'b1;
        step();
        step();
        b_req_tvalid = 2'b00;
        ok_a = 1'b1; ok_b = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (b_timeout !== 1'b0 || b_busy !== 1'b1) ok_a = 1'b0;
            if (b_rsp_tvalid !== 2'b00) ok_b = 1'b0;
        end
        chk("to_no_early_pulse", ok_a, 1);
        step();
        chk("to_pulse", b_timeout, 1);
        chk("to_idle", b_busy, 0);
        chk("to_no_rsp", b_rsp_tvalid, 0);
        step();
        chk("to_pulse_one_cycle", b_timeout, 0);
        chk("to_no_rsp_during_wait", ok_b, 1);

        // Late MISO word after the timeout, then a clean transaction
        b_miso_tdata = 16'h1234;
        b_miso_tvalid = 1'b1;
        step();
        b_miso_tvalid = 1'b0;
        chk("late_dropped", b_dropped, 1);
        chk("late_no_rsp", b_rsp_tvalid, 0);
        b_req_tvalid = 2'b01;
        b_req_tdata = {16'h0000, 16'h0A0A};
        step();
        chk("late_grant", b_grant, 0);
        step();
        b_req_tvalid = 2'b00;
        b_miso_tdata = 16'h00C3;
        b_miso_tvalid = 1'b1;
        step();
        b_miso_tvalid = 1'b0;
        chk("late_rsp_tvalid", b_rsp_tvalid, 2'b01);
        chk("late_rsp_tdata", b_rsp_tdata, 16'h00C3);
        b_rsp_tready = 2'b01;
        step();
        b_rsp_tready = 2'b00;
        chk("late_busy_done", b_busy, 0);

        // Requester drops valid in ISSUE: keeps grant, no timeout
        b_req_tvalid = 2'b10;
        b_req_tdata = {16'h5A5A, 16'h0000};
        b_cmd_tready = 1'b0;
        step();
        chk("iss_grant", b_grant, 1);
        b_req_tvalid = 2'b00;
        ok_a = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (b_busy !== 1'b1 || b_grant !== 1'b1 || b_timeout !== 1'b0 || b_cmd_tvalid !== 1'b0)
                ok_a = 1'b0;
        end
        chk("iss_hold_no_timeout", ok_a, 1);
        b_req_tvalid = 2'b10;
        b_cmd_tready = 1'b1;
        #1;
        chk("iss_req_tready", b_req_tready, 2'b10);
        chk("iss_cmd_tdata", b_cmd_tdata, 16'h5A5A);
        step();
        b_req_tvalid = 2'b00;
        reset = 1'b1; step(); reset = 1'b0;

        // dropped_count saturation
        b_miso_tvalid = 1'b1;
        repeat (255) step();
        chk("sat_255", b_dropped, 8'd255);
        repeat (5) step();
        b_miso_tvalid = 1'b0;
        chk("sat_hold", b_dropped, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_transaction_arbiter.md
SPI_TRANSACTION_ARBITER -- requirements
Module: spi_transaction_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQUESTERS, default 2, number of sharing drivers; TRANSFER_WIDTH, default 16, bits per SPI word; TIMEOUT_CYCLES, default 4096, cycles to wait for a response.
REQ-002 The port list SHALL be as follows, one port per line: name, direction, width, meaning.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- req_tdata  in  NUM_REQUESTERS*TRANSFER_WIDTH  per-requester command word; slice i belongs to requester i.
- req_tvalid  in  NUM_REQUESTERS  command valid.
- req_tready  out  NUM_REQUESTERS  command accepted.
- rsp_tdata  out  TRANSFER_WIDTH  response word, shared by all requesters.
- rsp_tvalid  out  NUM_REQUESTERS  response valid, one-hot.
- rsp_tready  in  NUM_REQUESTERS  response accepted.
- cmd_tdata / cmd_tvalid / cmd_tready  out/out/in  TRANSFER_WIDTH/1/1  command stream to the spi_master MOSI sink.
- miso_tdata / miso_tvalid / miso_tready  in/in/out  TRANSFER_WIDTH/1/1  response stream from the spi_master MISO source.
- grant  out  $clog2(NUM_REQUESTERS)  current owner.
- busy  out  1  high whenever the state is not IDLE.
- timeout  out  1  one-cycle pulse when a response wait expires.
- dropped_count  out  8  count of stale MISO words discarded; saturates at 255.

Function
REQ-003 The block SHALL allow exactly one outstanding SPI transaction: one command accepted, then one response returned to the same requester.
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT_RESP, DELIVER.
REQ-005 IDLE: if any req_tvalid is high, the block SHALL register grant as the round-robin winner, searching from last_grant+1 upward with wrap, and move to ISSUE the next cycle. req_tready SHALL be all zero in IDLE.
REQ-006 ISSUE: the command path SHALL be combinational.
- cmd_tdata = req_tdata slice [grant].
- cmd_tvalid = req_tvalid[grant].
- req_tready[grant] = cmd_tready; all other req_tready = 0.
- On cmd handshake: clear the timeout counter and go to WAIT_RESP.
REQ-007 WAIT_RESP: miso_tready SHALL be 1.
- On miso handshake: capture miso_tdata into the response register and go to DELIVER.
- Otherwise: increment the counter. When it equals TIMEOUT_CYCLES-1, pulse timeout for one cycle, set last_grant to grant, and go to IDLE.
REQ-008 DELIVER: rsp_tvalid[grant] SHALL be 1 and rsp_tdata SHALL hold the captured word.
- On rsp_tready[grant]: set last_grant to grant and go to IDLE.
- miso_tready SHALL be 0 in ISSUE and DELIVER.
REQ-009 IDLE: miso_tready SHALL be 1. Any MISO word accepted in IDLE (a late response after a timeout) SHALL be discarded and SHALL increment dropped_count, saturating at 255.
REQ-010 Minimum latency: grant one cycle after req_tvalid in IDLE; rsp_tvalid one cycle after the MISO handshake.
REQ-011 A requester that drops req_tvalid while in ISSUE SHALL keep the grant. The arbiter SHALL wait in ISSUE with no timeout.
REQ-012 All outputs except the ISSUE passthrough signals SHALL be registered.

Reset
REQ-013 On reset the block SHALL force:
- state = IDLE.
- grant = 0.
- last_grant = NUM_REQUESTERS-1, so requester 0 wins first.
- counter = 0, dropped_count = 0.
- timeout = 0, busy = 0.
- all rsp_tvalid = 0, all req_tready = 0, cmd_tvalid = 0.
REQ-014 A reset mid-transaction SHALL abandon the transaction. Neither requester receives a response for it. A MISO word arriving after reset SHALL be handled per REQ-009.

Structure
REQ-015 Package spi_arb_pkg SHALL hold the state enum spi_arb_state_t and the default constants for TRANSFER_WIDTH and TIMEOUT_CYCLES.
REQ-016 The round-robin search SHALL live in the sub-module rr_priority_picker. It is combinational: inputs are the request vector and last_grant; outputs are winner and any_valid.

Verification
REQ-017 Requester 0 only: req0 = 0xB200; MISO returns 0x00E5 after 200 cycles. Required: cmd_tdata = 0xB200, rsp_tvalid = 2'b01, rsp_tdata = 0x00E5, busy returns to 0.
REQ-018 Both requesters valid continuously, 6 transactions. Required grant sequence: 0, 1, 0, 1, 0, 1. Each rsp_tvalid goes only to the current owner.
REQ-019 TIMEOUT_CYCLES = 16; MISO never responds. Required: timeout pulses 16 cycles after the cmd handshake, FSM returns to IDLE, no rsp_tvalid.
REQ-020 Timeout case, then a late MISO word 0x1234 arrives in IDLE. Required: dropped_count = 1; the next transaction returns its own data, not 0x1234.
REQ-021 Reset asserted in WAIT_RESP. Required: busy = 0 and rsp_tvalid = 0 the next cycle; the next request from requester 1 is served with requester 0 idle.
REQ-022 Hold rsp_tready[1] = 0 for 50 cycles in DELIVER. Required: rsp_tvalid[1] and rsp_tdata stay stable; miso_tready = 0 throughout; no new grant.
